// File: rtl/arbitro_suma.sv
// arbitro_suma: one shared ANCHO-bit adder arbitrated round-robin between two
// requesters (port 0: PC increment, port 1: branch target). The sum is
// registered into a single-entry output buffer drained by a valid/ready
// handshake.
//
// Optional feature macro: ARBITRO_SUMA_CARRY_EN adds a registered res_carry
// output (carry-out of the sum) and widens the adder to ANCHO+1 bits.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/req0_a/req0_b        requester 0 operand pair
//   req0_ready                      requester 0 accepted this cycle (comb)
//   req1_valid/req1_a/req1_b        requester 1 operand pair
//   req1_ready                      requester 1 accepted this cycle (comb)
//   res_valid/res_dato/res_id       buffered result, its owner index
//   res_ready                       downstream accepts the result
//   res_carry                       carry-out (ARBITRO_SUMA_CARRY_EN only)
module arbitro_suma #(
  parameter int unsigned ANCHO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [ANCHO-1:0] req0_a,
  input  logic [ANCHO-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [ANCHO-1:0] req1_a,
  input  logic [ANCHO-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [ANCHO-1:0] res_dato,
  output logic             res_id,
  input  logic             res_ready
`ifdef ARBITRO_SUMA_CARRY_EN
  ,
  output logic             res_carry
`endif
);

  localparam logic [0:0] VACIO = 1'b0;
  localparam logic [0:0] LLENO = 1'b1;

  logic [0:0]       estado;
  logic [0:0]       estado_sig;
  logic             ultimo;
  logic             gnt0;
  logic             gnt1;
  logic             libre;
  logic             xfer0;
  logic             xfer1;
  logic             xfer;
  logic [ANCHO-1:0] op_a;
  logic [ANCHO-1:0] op_b;
`ifdef ARBITRO_SUMA_CARRY_EN
  logic [ANCHO:0]   suma;
`else
  logic [ANCHO-1:0] suma;
`endif

  // Round-robin grant: a lone requester wins; on a tie the one not served last
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ultimo);
    gnt1 = req1_valid & (~req0_valid | ~ultimo);
  end

  // Buffer can take a new sum if empty or being drained this cycle.
  // rst_n gating keeps both readies low while reset is asserted.
  always_comb begin
    libre      = (estado == VACIO) | res_ready;
    req0_ready = rst_n & gnt0 & libre;
    req1_ready = rst_n & gnt1 & libre;
    xfer0      = req0_valid & req0_ready;
    xfer1      = req1_valid & req1_ready;
    xfer       = xfer0 | xfer1;
  end

  // Shared adder operand mux and sum
  always_comb begin
    op_a = xfer1 ? req1_a : req0_a;
    op_b = xfer1 ? req1_b : req0_b;
`ifdef ARBITRO_SUMA_CARRY_EN
    suma = {1'b0, op_a} + {1'b0, op_b};
`else
    suma = op_a + op_b;
`endif
  end

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= VACIO;
    else        estado <= estado_sig;
  end

  // Next state: a transfer always fills; a drain without refill empties
  always_comb begin
    estado_sig = estado;
    if (xfer)                                estado_sig = LLENO;
    else if ((estado == LLENO) && res_ready) estado_sig = VACIO;
  end

  assign res_valid = (estado == LLENO);

  // Result payload and last-grant pointer; ultimo resets to 1 so port 0
  // wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_dato  <= '0;
      res_id    <= 1'b0;
      ultimo    <= 1'b1;
`ifdef ARBITRO_SUMA_CARRY_EN
      res_carry <= 1'b0;
`endif
    end else if (xfer) begin
      res_dato  <= suma[ANCHO-1:0];
      res_id    <= xfer1;
      ultimo    <= xfer1;
`ifdef ARBITRO_SUMA_CARRY_EN
      res_carry <= suma[ANCHO];
`endif
    end
  end

endmodule
